memory_arbiter: RTL

Two-to-one round-robin arbiter that lets two memory masters (e.g. instruction and data fetch paths) share a single memory slave over the team's MemoryInterface handshake. It presents a slave-side MemoryInterface to each master and a master-side MemoryInterface to the memory. Each transaction is forwarded unchanged. At most one master owns the memory at a time.

---
 rtl/memory_pkg.sv | 11 +
 rtl/memory_arbiter_if.sv | 23 ++
 rtl/memory_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// Shared memory-subsystem types used by the arbiter and its neighbours.
// Pure type definitions; no logic, latency or flow control of its own.
package memory_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } arbiter_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// MemoryInterface: request/complete handshake between a memory master and slave.
// Enables held with address/dataOut stable until a one-cycle functionComplete pulse.
interface MemoryInterface #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0]    dataOut;
  logic [DATA_WIDTH-1:0]    dataIn;
  logic                     writeEnabled;
  logic                     readEnabled;
  logic                     functionComplete;

  modport master (
    output address, dataOut, writeEnabled, readEnabled,
    input  dataIn, functionComplete
  );

  modport slave (
    input  address, dataOut, writeEnabled, readEnabled,
    output dataIn, functionComplete
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-to-one round-robin memory arbiter: 1-cycle grant latency, 0-cycle completion pass-through.
// A waiting master simply holds its enables; it is forwarded one IDLE cycle after the owner completes.
module memory_arbiter
  import memory_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input logic            clock,
  input logic            reset,
  MemoryInterface.slave  master0,
  MemoryInterface.slave  master1,
  MemoryInterface.master memory
);

  arbiter_state_t           state;
  arbiter_state_t           stateNext;
  logic                     lastGranted;
  logic                     lastGrantedNext;
  logic                     request0;
  logic                     request1;
  logic [ADDRESS_WIDTH-1:0] routedAddress;
  logic [DATA_WIDTH-1:0]    routedDataOut;
  logic                     routedRead;
  logic                     routedWrite;

  assign request0 = master0.readEnabled | master0.writeEnabled;
  assign request1 = master1.readEnabled | master1.writeEnabled;

  // lastGranted resets to 1 so master0 wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lastGranted <= 1'b1;
    end else begin
      state       <= stateNext;
      lastGranted <= lastGrantedNext;
    end
  end

  always_comb begin
    stateNext       = state;
    lastGrantedNext = lastGranted;
    case (state)
      IDLE: begin
        if (request0 && request1) begin
          stateNext = lastGranted ? GRANT0 : GRANT1;
        end else if (request0) begin
          stateNext = GRANT0;
        end else if (request1) begin
          stateNext = GRANT1;
        end
      end
      GRANT0: begin
        if (memory.functionComplete) begin
          stateNext       = IDLE;
          lastGrantedNext = 1'b0;
        end
      end
      GRANT1: begin
        if (memory.functionComplete) begin
          stateNext       = IDLE;
          lastGrantedNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Everything is zeroed unless a grant is held, so a completion seen in IDLE goes nowhere.
  always_comb begin
    routedAddress            = '0;
    routedDataOut            = '0;
    routedRead               = 1'b0;
    routedWrite              = 1'b0;
    master0.dataIn           = '0;
    master0.functionComplete = 1'b0;
    master1.dataIn           = '0;
    master1.functionComplete = 1'b0;
    case (state)
      GRANT0: begin
        routedAddress            = master0.address;
        routedDataOut            = master0.dataOut;
        routedRead               = master0.readEnabled;
        routedWrite              = master0.writeEnabled;
        master0.dataIn           = memory.dataIn;
        master0.functionComplete = memory.functionComplete;
      end
      GRANT1: begin
        routedAddress            = master1.address;
        routedDataOut            = master1.dataOut;
        routedRead               = master1.readEnabled;
        routedWrite              = master1.writeEnabled;
        master1.dataIn           = memory.dataIn;
        master1.functionComplete = memory.functionComplete;
      end
      default: ;
    endcase
  end

  assign memory.address      = routedAddress;
  assign memory.dataOut      = routedDataOut;
  assign memory.readEnabled  = routedRead;
  assign memory.writeEnabled = routedWrite;

endmodule
